// File: rtl/wash_cycle_sequencer.sv
// Washing-machine cycle sequencer: IDLE -> FILL -> HEAT -> WASH -> RINSE -> SPIN -> DONE, with a sticky FAULT state.
// Latency: state and every actuator output are registered together, so both change on the clock edge after the inputs that cause them.
// Backpressure: none. The time base is the 'tick' pulse. The optional PAUSE_EN build freezes FILL..SPIN while 'pause' is high.
//
// Ports: clk/reset (async, active-high); tick time base; start/pause/door_closed/water_full levels;
//        wash_mode (3 = quick wash) and target_temp are latched at cycle start; water_temp is the sensor value.
//        Outputs: door_lock, water_valve, heater_on, drain_pump, drum_motor (00 off/01 slow/10 fast),
//        temp_locked, phase (= state code), done (one-cycle pulse), fault.
// Build option: define PAUSE_EN to include pause support. Without it, the pause input is ignored.
module wash_cycle_sequencer #(
    parameter int FILL_TIMEOUT = 20,
    parameter int WASH_TICKS   = 40,
    parameter int RINSE_TICKS  = 16,
    parameter int SPIN_TICKS   = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       pause,
    input  logic       door_closed,
    input  logic       water_full,
    input  logic [2:0] wash_mode,
    input  logic [6:0] target_temp,
    input  logic [6:0] water_temp,
    output logic       door_lock,
    output logic       water_valve,
    output logic       heater_on,
    output logic       drain_pump,
    output logic [1:0] drum_motor,
    output logic       temp_locked,
    output logic [2:0] phase,
    output logic       done,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_HEAT  = 3'd2,
        S_WASH  = 3'd3,
        S_RINSE = 3'd4,
        S_SPIN  = 3'd5,
        S_DONE  = 3'd6,
        S_FAULT = 3'd7
    } state_t;

    localparam logic [8:0] FILL_LIM  = 9'(FILL_TIMEOUT);
    localparam logic [8:0] WASH_LIM  = 9'(WASH_TICKS);
    localparam logic [8:0] QUICK_LIM = 9'(WASH_TICKS / 2);
    localparam logic [8:0] RINSE_LIM = 9'(RINSE_TICKS);
    localparam logic [8:0] SPIN_LIM  = 9'(SPIN_TICKS);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] mode_q, mode_d;
    logic [6:0] target_q, target_d;

    logic       door_lock_q, door_lock_d;
    logic       water_valve_q, water_valve_d;
    logic       heater_on_q, heater_on_d;
    logic       drain_pump_q, drain_pump_d;
    logic [1:0] drum_motor_q, drum_motor_d;
    logic       temp_locked_q, temp_locked_d;
    logic [2:0] phase_q, phase_d;
    logic       done_q, done_d;
    logic       fault_q, fault_d;

    logic       active;
    logic       paused;
    logic       hold;
    logic [8:0] cnt_inc;
    logic [8:0] wash_lim;

    // The running phases are the only ones affected by door-open and pause.
    assign active = (state_q == S_FILL) || (state_q == S_HEAT) || (state_q == S_WASH) ||
                    (state_q == S_RINSE) || (state_q == S_SPIN);

`ifdef PAUSE_EN
    assign paused = active & pause;
`else
    logic unused_pause;
    assign paused       = 1'b0;
    assign unused_pause = pause;
`endif

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        target_d = target_q;
        wash_lim = (mode_q == 3'd3) ? QUICK_LIM : WASH_LIM;
        // cnt_inc is the count including this edge's tick. A phase ends on the
        // edge whose tick reaches the limit, and that tick is not carried into
        // the next phase.
        cnt_inc  = {1'b0, cnt_q} + {8'd0, tick & ~paused};

        if (!paused) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start && door_closed) begin
                        state_d  = S_FILL;
                        mode_d   = wash_mode;
                        target_d = target_temp;
                    end
                end
                S_FILL: begin
                    // A full tank takes priority over a timeout on the same edge.
                    if (water_full)                state_d = S_HEAT;
                    else if (cnt_inc >= FILL_LIM)  state_d = S_FAULT;
                end
                S_HEAT:  if (water_temp >= target_q)  state_d = S_WASH;
                S_WASH:  if (cnt_inc >= wash_lim)     state_d = S_RINSE;
                S_RINSE: if (cnt_inc >= RINSE_LIM)    state_d = S_SPIN;
                S_SPIN:  if (cnt_inc >= SPIN_LIM)     state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_FAULT;
            endcase
        end

        // An open door in a running phase wins over everything, paused or not.
        if (active && !door_closed) state_d = S_FAULT;

        cnt_d = (state_d != state_q) ? 8'd0 : cnt_inc[7:0];
        hold  = paused && (state_d == state_q);

        // Outputs are decoded from the next state so they register alongside it.
        water_valve_d = 1'b0;
        heater_on_d   = 1'b0;
        drain_pump_d  = 1'b0;
        drum_motor_d  = 2'b00;
        done_d        = 1'b0;
        fault_d       = 1'b0;
        unique case (state_d)
            S_FILL:  water_valve_d = 1'b1;
            S_HEAT:  begin heater_on_d = 1'b1; drum_motor_d = 2'b01; end
            S_WASH:  drum_motor_d = 2'b01;
            S_RINSE: begin water_valve_d = 1'b1; drain_pump_d = 1'b1; drum_motor_d = 2'b01; end
            S_SPIN:  begin drain_pump_d = 1'b1; drum_motor_d = 2'b10; end
            S_DONE:  done_d = 1'b1;
            S_FAULT: begin fault_d = 1'b1; drain_pump_d = 1'b1; end
            default: ;
        endcase
        if (hold) begin
            water_valve_d = 1'b0;
            heater_on_d   = 1'b0;
            drain_pump_d  = 1'b0;
            drum_motor_d  = 2'b00;
        end
        door_lock_d   = (state_d != S_IDLE);
        temp_locked_d = (state_d != S_IDLE);
        phase_d       = state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= 8'd0;
            mode_q        <= 3'd0;
            target_q      <= 7'd0;
            door_lock_q   <= 1'b0;
            water_valve_q <= 1'b0;
            heater_on_q   <= 1'b0;
            drain_pump_q  <= 1'b0;
            drum_motor_q  <= 2'b00;
            temp_locked_q <= 1'b0;
            phase_q       <= 3'd0;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mode_q        <= mode_d;
            target_q      <= target_d;
            door_lock_q   <= door_lock_d;
            water_valve_q <= water_valve_d;
            heater_on_q   <= heater_on_d;
            drain_pump_q  <= drain_pump_d;
            drum_motor_q  <= drum_motor_d;
            temp_locked_q <= temp_locked_d;
            phase_q       <= phase_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
        end
    end

    assign door_lock   = door_lock_q;
    assign water_valve = water_valve_q;
    assign heater_on   = heater_on_q;
    assign drain_pump  = drain_pump_q;
    assign drum_motor  = drum_motor_q;
    assign temp_locked = temp_locked_q;
    assign phase       = phase_q;
    assign done        = done_q;
    assign fault       = fault_q;

endmodule

// File: doc/wash_cycle_sequencer.md
WASH_CYCLE_SEQUENCER -- requirements
Module: wash_cycle_sequencer

Interface
REQ-001 SHALL have parameter FILL_TIMEOUT, default 20, max ticks allowed in FILL before fault.
REQ-002 SHALL have parameter WASH_TICKS, default 40, WASH duration in ticks (must be even).
REQ-003 SHALL have parameter RINSE_TICKS, default 16, RINSE duration in ticks.
REQ-004 SHALL have parameter SPIN_TICKS, default 12, SPIN duration in ticks.
REQ-005 SHALL have ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- tick  in  1  one-clk time-base pulse; all durations counted in ticks
- start  in  1  level; request to begin a cycle
- pause  in  1  level; hold current phase
- door_closed  in  1  door sensor, 1 = closed
- water_full  in  1  level sensor
- wash_mode  in  3  mode code; 3 = QUICK_WASH
- target_temp  in  7  temperature from the temperature selector, degrees C
- water_temp  in  7  measured water temperature, degrees C
- door_lock  out  1  door lock solenoid
- water_valve  out  1  inlet valve
- heater_on  out  1  heater
- drain_pump  out  1  drain pump
- drum_motor  out  2  00 off, 01 slow, 10 fast
- temp_locked  out  1  freezes the temperature selector while 1
- phase  out  3  current state encoding
- done  out  1  cycle-complete pulse
- fault  out  1  fault indicator

Function
REQ-006 SHALL implement states IDLE=0, FILL=1, HEAT=2, WASH=3, RINSE=4, SPIN=5, DONE=6, FAULT=7; phase = state.
REQ-007 SHALL leave IDLE for FILL only when start=1 and door_closed=1 on the same clk edge; start in any other state or with door open ignored.
REQ-008 SHALL latch wash_mode and target_temp at the IDLE->FILL edge; later changes have no effect until next cycle.
REQ-009 SHALL use one 8-bit tick counter, cleared on every state entry, incremented only on clk edges with tick=1 (and not paused); a tick coincident with a state change is not counted in the new state.
REQ-010 FILL: water_valve=1; go to HEAT when water_full=1; go to FAULT when counter reaches FILL_TIMEOUT with water_full=0; water_full wins if both occur on the same edge.
REQ-011 HEAT: heater_on=1, drum_motor=01; go to WASH on the first edge where water_temp >= latched target; if true on entry, HEAT lasts exactly one clk cycle.
REQ-012 WASH: drum_motor=01; go to RINSE when counter reaches WASH_TICKS, or WASH_TICKS/2 when latched mode = 3.
REQ-013 RINSE: water_valve=1, drain_pump=1, drum_motor=01; go to SPIN when counter reaches RINSE_TICKS.
REQ-014 SPIN: drain_pump=1, drum_motor=10; go to DONE when counter reaches SPIN_TICKS.
REQ-015 DONE: done=1 for exactly one clk cycle, then IDLE.
REQ-016 door_lock=1 and temp_locked=1 in FILL, HEAT, WASH, RINSE, SPIN, DONE, FAULT; 0 in IDLE.
REQ-017 door_closed=0 in FILL..SPIN (paused or not) SHALL force FAULT on that edge, overriding every other transition.
REQ-018 FAULT: fault=1, drain_pump=1, all other actuators 0, door_lock=1; exit only via reset.
REQ-019 Actuator outputs SHALL be registered, changing on the same edge as the state.

Reset
REQ-020 reset SHALL immediately force IDLE, counter 0, latched mode/target 0, and all outputs 0 (drum_motor=00, phase=0).
REQ-021 reset asserted mid-cycle SHALL abandon the cycle with no done pulse; next cycle requires a fresh start.

Configuration
REQ-022 With PAUSE_EN defined: pause=1 in FILL..SPIN freezes state and counter, drives water_valve, heater_on, drain_pump, drum_motor to 0, keeps door_lock=1; pause=0 resumes the same state with the same counter value.
REQ-023 Without PAUSE_EN: pause input ignored; no pause logic synthesized.

Verification (FILL_TIMEOUT=4, WASH_TICKS=4, RINSE_TICKS=2, SPIN_TICKS=2, tick every 4 clks)
REQ-024 start, door closed, water_full after 2 ticks, target 40, water_temp 45 -> FILL,HEAT(1 clk),WASH 4 ticks,RINSE 2,SPIN 2,DONE 1-clk done pulse, IDLE, door_lock 0.
REQ-025 wash_mode=3 -> WASH lasts 2 ticks; target_temp changed 40->60 during HEAT -> HEAT still exits at water_temp >= 40.
REQ-026 water_full held 0 -> FAULT after 4th tick in FILL, fault=1, drain_pump=1, persists until reset.
REQ-027 door_closed dropped during WASH -> FAULT next edge; start with door open in IDLE -> stays IDLE.
REQ-028 PAUSE_EN: pause 3 ticks during WASH at count 2 -> motor 00, phase 3 held, WASH resumes and ends after 2 more ticks; without PAUSE_EN same stimulus -> no effect.
REQ-029 reset asserted during SPIN -> all outputs 0 asynchronously, no done pulse, phase 0.
